// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and types for the pipelined add/subtract block.
//
//   ADDSUB_WIDTH / ADDSUB_LO_W   default operand width and low-slice width
//   OP_ADD / OP_SUB              encoding of the 'sub' request bit
//   s1_t                         contents of the stage-1 register
//   result_t                     one retired result {ans, cout, v}
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 32;
    localparam int ADDSUB_LO_W  = 16;
    localparam int ADDSUB_HI_W  = ADDSUB_WIDTH - ADDSUB_LO_W;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [ADDSUB_HI_W-1:0] a_hi;
        logic [ADDSUB_HI_W-1:0] b_eff_hi;
        logic [ADDSUB_LO_W-1:0] lo_sum;
        logic                   c_lo;
        logic                   sub;
    } s1_t;

    typedef struct packed {
        logic [ADDSUB_WIDTH-1:0] ans;
        logic                    cout;
        logic                    v;
    } result_t;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational W-bit adder with carry-in.
//
//   a, b        in   W  addends
//   cin         in   1  carry in
//   sum         out  W  (a + b + cin) mod 2^W
//   cout        out  1  carry out of the MSB
//   c_into_msb  out  1  carry into the MSB (for signed overflow)
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int W = ADDSUB_LO_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_into_msb
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_into_msb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/addsub32_pipe.sv
// addsub32_pipe: two-stage pipelined adder/subtractor with valid/ready on
// both sides. Stage 1 adds the low LO_W bits, stage 2 the remaining bits
// using the registered low carry.
//
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; a, b, sub sampled on accept
//   out_valid/out_ready  result handshake; ans, cout, v valid with out_valid
//   op_count, ovf_count  only when ADDSUB_STATS_EN is defined: retired-op
//                        count (wraps) and overflow count (saturates)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// Ready propagates combinationally backwards (no skid buffer):
//   s2_ready = !out_valid || out_ready
//   s1_ready = !s1_valid  || s2_ready
//   in_ready = s1_ready && !rst
// The pipeline holds at most two ops.
module addsub32_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int LO_W  = ADDSUB_LO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ADDSUB_STATS_EN
    output logic [31:0]      op_count,
    output logic [15:0]      ovf_count,
`endif
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             v
);

    localparam int HI_W = WIDTH - LO_W;

    // ---------------- stage 1: low slice ----------------
    logic [WIDTH-1:0] b_eff;
    logic [LO_W-1:0]  lo_sum_c;
    logic             c_lo_c;
    logic             unused_lo_msb;

    assign b_eff = b ^ {WIDTH{sub == OP_SUB}};

    addsub_slice #(.W(LO_W)) u_lo (
        .a          (a[LO_W-1:0]),
        .b          (b_eff[LO_W-1:0]),
        .cin        (sub),
        .sum        (lo_sum_c),
        .cout       (c_lo_c),
        .c_into_msb (unused_lo_msb)
    );

    logic            s1_valid;
    logic [HI_W-1:0] s1_a_hi;
    logic [HI_W-1:0] s1_b_eff_hi;
    logic [LO_W-1:0] s1_lo_sum;
    logic            s1_c_lo;
    logic            s1_sub;
    logic            unused_s1_sub;

    // The op bit rides along with the stage for visibility; the high
    // slice already sees the inverted operand, so it needs nothing more.
    assign unused_s1_sub = s1_sub;

    // ---------------- stage 2: high slice ----------------
    logic [HI_W-1:0] hi_sum_c;
    logic            hi_cout_c;
    logic            hi_cmsb_c;

    addsub_slice #(.W(HI_W)) u_hi (
        .a          (s1_a_hi),
        .b          (s1_b_eff_hi),
        .cin        (s1_c_lo),
        .sum        (hi_sum_c),
        .cout       (hi_cout_c),
        .c_into_msb (hi_cmsb_c)
    );

    // ---------------- handshake ----------------
    logic s2_ready;
    logic s1_ready;
    logic in_fire;
    logic s1_fire;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready && !rst;
    assign in_fire  = in_valid && in_ready;
    assign s1_fire  = s1_valid && s2_ready;

    // Valid bits and output registers: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            ans       <= '0;
            cout      <= 1'b0;
            v         <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s1_fire) begin
                ans  <= {hi_sum_c, s1_lo_sum};
                cout <= hi_cout_c;
                v    <= hi_cmsb_c ^ hi_cout_c;
            end
        end
    end

    // Stage-1 payload: only loads on an accepted request, so idle inputs
    // (possibly X) never enter the pipe. No reset needed: s1_valid guards it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a_hi     <= a[WIDTH-1:LO_W];
            s1_b_eff_hi <= b_eff[WIDTH-1:LO_W];
            s1_lo_sum   <= lo_sum_c;
            s1_c_lo     <= c_lo_c;
            s1_sub      <= sub;
        end
    end

`ifdef ADDSUB_STATS_EN
    // ---------------- statistics ----------------
    logic out_fire;

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + 32'd1;
            if (v && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_addsub32_pipe.sv
module tb_addsub32_pipe;
  import addsub_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ans;
  logic        cout;
  logic        v;
`ifdef ADDSUB_STATS_EN
  logic [31:0] op_count;
  logic [15:0] ovf_count;
`endif

  always #5 clk = ~clk;

  addsub32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ADDSUB_STATS_EN
    .op_count  (op_count),
    .ovf_count (ovf_count),
`endif
    .ans       (ans),
    .cout      (cout),
    .v         (v)
  );

  // ---------------- bookkeeping ----------------
  int      n_checks = 0;
  int      n_fail   = 0;
  result_t exp_q[$];
  bit      tally_en = 0;
  int      ovf_tally = 0;
  bit      rnd_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain A+B / A-B arithmetic; overflow from exact signed result.
  function automatic result_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    result_t r;
    longint  sx;
    longint  sy;
    longint  rs;
    sx = $signed(x);
    sy = $signed(y);
    rs = s ? (sx - sy) : (sx + sy);
    r.ans  = s ? (x - y) : (x + y);
    r.cout = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF);
    r.v    = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    result_t r;
    r = model(x, y, s);
    exp_q.push_back(r);
    if (tally_en && r.v) ovf_tally++;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_op(x, y, s);
        ok = 1;
      end
      step();
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom_range(0, 1));
    if (!ok) chk("send_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  // Empty pipe, out_ready=1: result must appear exactly two edges after
  // the request is first presented, and not one edge earlier.
  task automatic lat_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input result_t exp);
    send_op(x, y, s);
    chk({name, "_not_early"}, {63'd0, out_valid}, 64'd0);
    step();
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, "_result"}, {30'd0, ans, cout, v}, {30'd0, exp});
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    step();
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit        prev_stall = 0;
  logic [33:0] held;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
          chk("stall_hold_data", {30'd0, ans, cout, v}, {30'd0, held});
        end
        prev_stall = out_valid && !out_ready;
        held = {ans, cout, v};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_out", {63'd0, out_valid}, 64'd0);
          end else begin
            result_t e;
            e = exp_q.pop_front();
            chk("sb_result", {30'd0, ans, cout, v}, {30'd0, e});
          end
        end
      end
    end
  end

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog.
  initial begin
    #900000;
    chk("watchdog_expired", {63'd0, out_valid}, 64'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [31:0] edge_vals [6];

  initial begin
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h7FFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h0000_0001;
    edge_vals[5] = 32'h0000_FFFF;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_outputs", {30'd0, ans, cout, v}, 64'd0);
    step();

    // Signed overflow on add, with fixed latency.
    out_ready = 1'b1;
    lat_op("ovf_add", 32'h7FFF_FFFF, 32'h1, OP_ADD, {32'h8000_0000, 1'b0, 1'b1});
    step();

    // Subtract borrow / no-borrow, slice boundary, wrap-around.
    send_op(32'h0, 32'h1, OP_SUB);
    send_op(32'h5, 32'h5, OP_SUB);
    send_op(32'h0000_FFFF, 32'h1, OP_ADD);
    send_op(32'hFFFF_FFFF, 32'h1, OP_ADD);
    send_op(32'h8000_0000, 32'h1, OP_SUB);
    drain();

    // Backpressure: two ops fill the pipe, the third is refused.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'h1111_1111; b = 32'h2222_2222; sub = OP_ADD;
    @(negedge clk);
    chk("bp_accept1", {63'd0, in_ready}, 64'd1);
    push_op(a, b, sub);
    step();
    a = 32'h0000_0010; b = 32'h0000_0020; sub = OP_SUB;
    @(negedge clk);
    chk("bp_accept2", {63'd0, in_ready}, 64'd1);
    push_op(a, b, sub);
    step();
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = OP_ADD;
    repeat (3) begin
      @(negedge clk);
      chk("bp_refuse3", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept3_on_release", {63'd0, in_ready}, 64'd1);
    push_op(a, b, sub);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_stream2", {63'd0, out_valid}, 64'd1);
    step();
    @(negedge clk);
    chk("bp_stream3", {63'd0, out_valid}, 64'd1);
    step();
    @(negedge clk);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    drain();

    // Reset with two ops in flight: they must vanish.
    out_ready = 1'b0;
    send_op(32'hAAAA_0000, 32'h0000_5555, OP_ADD);
    send_op(32'h0BAD_F00D, 32'h0000_0001, OP_SUB);
    step();
    do_reset();
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_valid", {63'd0, out_valid}, 64'd0);
      step();
    end
    lat_op("post_reset", 32'h1234_0000, 32'h0000_4321, OP_ADD,
           model(32'h1234_0000, 32'h0000_4321, OP_ADD));
    drain();

    // Random traffic with random backpressure.
    do_reset();
    tally_en = 1;
    ovf_tally = 0;
    rnd_ready = 1;
    for (int i = 0; i < 5000; ) begin
      if ($urandom_range(0, 9) < 7) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
        send_op(ra, rb, 1'($urandom_range(0, 1)));
        i++;
      end else begin
        step();
      end
    end
    rnd_ready = 0;
    #1;
    out_ready = 1'b1;
    drain();
`ifdef ADDSUB_STATS_EN
    chk("op_count", 64'(op_count), 64'd5000);
    chk("ovf_count", 64'(ovf_count), (ovf_tally > 65535) ? 64'd65535 : 64'(ovf_tally));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
